// File: rtl/threshold_debounce_fsm.sv
// Debounces comparator lesser/greater/equal flags with hysteresis into a
// registered alarm, with one-cycle rise/fall pulses, a malformed-flag pulse
// and a saturating count of alarm rises.
module threshold_debounce_fsm #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             lesser,
  input  logic             greater,
  input  logic             equal,
  input  logic             clear_count,
  output logic             alarm,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_count,
  output logic             flag_error
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    ARMING    = 2'd1,
    HIGH      = 2'd2,
    DISARMING = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic             onehot, accept;
  logic             alarm_nxt, rise_nxt, fall_nxt, ferr_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Exactly one flag set; a sample only counts when it is valid and one-hot.
  assign onehot  = (lesser ^ greater ^ equal) & ~(lesser & greater & equal);
  assign accept  = in_valid & onehot;
  assign run_inc = run + 1'b1;

  // State and registered outputs; rst discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOW;
      run         <= '0;
      alarm       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      event_count <= '0;
      flag_error  <= 1'b0;
    end else begin
      state       <= state_nxt;
      run         <= run_nxt;
      alarm       <= alarm_nxt;
      rise_pulse  <= rise_nxt;
      fall_pulse  <= fall_nxt;
      event_count <= count_nxt;
      flag_error  <= ferr_nxt;
    end
  end

  // Next state: equal holds a run in progress, an opposing flag cancels it.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (accept) begin
      unique case (state)
        LOW: begin
          if (greater) begin
            if (DEBOUNCE == 1) begin
              state_nxt = HIGH;
              run_nxt   = '0;
            end else begin
              state_nxt = ARMING;
              run_nxt   = RUN_ONE;
            end
          end else begin
            run_nxt = '0;
          end
        end
        ARMING: begin
          if (greater) begin
            if (run_inc == RUN_LAST) begin
              state_nxt = HIGH;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end else if (lesser) begin
            state_nxt = LOW;
            run_nxt   = '0;
          end
        end
        HIGH: begin
          if (lesser) begin
            if (DEBOUNCE == 1) begin
              state_nxt = LOW;
              run_nxt   = '0;
            end else begin
              state_nxt = DISARMING;
              run_nxt   = RUN_ONE;
            end
          end else begin
            run_nxt = '0;
          end
        end
        DISARMING: begin
          if (lesser) begin
            if (run_inc == RUN_LAST) begin
              state_nxt = LOW;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end else if (greater) begin
            state_nxt = HIGH;
            run_nxt   = '0;
          end
        end
        default: begin
          state_nxt = LOW;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // Output values to be registered; edges derive from the alarm transition.
  always_comb begin
    alarm_nxt = (state_nxt == HIGH) || (state_nxt == DISARMING);
    rise_nxt  = alarm_nxt & ~alarm;
    fall_nxt  = ~alarm_nxt & alarm;
    ferr_nxt  = in_valid & ~onehot;
    count_nxt = event_count;
    if (clear_count) begin
      count_nxt = rise_nxt ? CNT_W'(1) : '0;
    end else if (rise_nxt && (event_count != {CNT_W{1'b1}})) begin
      count_nxt = event_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_threshold_debounce_fsm.sv
// Bench for threshold_debounce_fsm: two instances (CNT_W=8 and CNT_W=2)
// share stimulus; a behavioural alarm/run model predicts every output.
module tb_threshold_debounce_fsm;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, lesser, greater, equal, clear_count;
  logic       alarm, rise_pulse, fall_pulse, flag_error;
  logic [7:0] event_count;
  logic       alarm2, rise2, fall2, ferr2;
  logic [1:0] event_count2;

  int compared   = 0;
  int mismatched = 0;

  // Model: alarm level, number of consecutive samples pushing toward the
  // opposite level, and the predicted registered outputs.
  int m_alarm, m_run, m_rise, m_fall, m_ferr, m_cnt8, m_cnt2;

  threshold_debounce_fsm #(.DEBOUNCE(D), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .lesser(lesser),
    .greater(greater), .equal(equal), .clear_count(clear_count),
    .alarm(alarm), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_count(event_count), .flag_error(flag_error)
  );

  threshold_debounce_fsm #(.DEBOUNCE(D), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .lesser(lesser),
    .greater(greater), .equal(equal), .clear_count(clear_count),
    .alarm(alarm2), .rise_pulse(rise2), .fall_pulse(fall2),
    .event_count(event_count2), .flag_error(ferr2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int toward, against, onehot;
    if (rst) begin
      m_alarm = 0; m_run = 0; m_rise = 0; m_fall = 0; m_ferr = 0;
      m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    onehot  = (int'(greater) + int'(lesser) + int'(equal)) == 1;
    m_rise  = 0;
    m_fall  = 0;
    m_ferr  = (in_valid && !onehot) ? 1 : 0;
    if (in_valid && onehot) begin
      toward  = m_alarm ? lesser : greater;
      against = m_alarm ? greater : lesser;
      if (toward) begin
        m_run++;
        if (m_run == D) begin
          m_alarm = 1 - m_alarm;
          m_run   = 0;
          if (m_alarm) m_rise = 1; else m_fall = 1;
        end
      end else if (against) begin
        m_run = 0;
      end
    end
    if (clear_count) begin
      m_cnt8 = m_rise;
      m_cnt2 = m_rise;
    end else if (m_rise) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  // Advance one clock with the currently driven inputs and check everything.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("alarm", alarm, m_alarm);
    chk("rise_pulse", rise_pulse, m_rise);
    chk("fall_pulse", fall_pulse, m_fall);
    chk("flag_error", flag_error, m_ferr);
    chk("event_count", event_count, m_cnt8);
    chk("alarm_c2", alarm2, m_alarm);
    chk("event_count_c2", event_count2, m_cnt2);
  endtask

  task automatic drive(input bit v, input bit g, input bit l, input bit e, input bit c = 1'b0);
    in_valid = v; greater = g; lesser = l; equal = e; clear_count = c;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic gs(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0);
  endtask

  task automatic ls(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; greater = 0; lesser = 0; equal = 0; clear_count = 0;
    m_alarm = 0; m_run = 0; m_rise = 0; m_fall = 0; m_ferr = 0; m_cnt8 = 0; m_cnt2 = 0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_alarm", alarm, 0);
    chk("rst_count", event_count, 0);

    // 1: four greater samples raise the alarm
    gs(3);
    chk("t1_no_early_rise", alarm, 0);
    gs(1);
    chk("t1_alarm", alarm, 1);
    chk("t1_rise", rise_pulse, 1);
    drive(0, 0, 0, 0);
    chk("t1_rise_one_cycle", rise_pulse, 0);
    chk("t1_count", event_count, 1);

    // 2: an interrupting lesser restarts the run
    do_reset();
    gs(3); ls(1);
    chk("t2_no_rise", alarm, 0);
    gs(3);
    chk("t2_still_low", alarm, 0);
    gs(1);
    chk("t2_rise", rise_pulse, 1);
    chk("t2_count", event_count, 1);

    // 3: equal samples and invalid cycles hold the run
    do_reset();
    drive(1, 1, 0, 0); drive(1, 0, 0, 1); drive(1, 1, 0, 0);
    drive(0, 1, 0, 0); drive(1, 0, 0, 1); drive(1, 1, 0, 0);
    chk("t3_before_4th", alarm, 0);
    drive(1, 1, 0, 0);
    chk("t3_alarm", alarm, 1);

    // 4: falling with a greater interruption
    ls(3); gs(1);
    chk("t4_held_high", alarm, 1);
    ls(3);
    chk("t4_still_high", alarm, 1);
    ls(1);
    chk("t4_alarm_low", alarm, 0);
    chk("t4_fall", fall_pulse, 1);
    drive(0, 0, 0, 0);
    chk("t4_fall_one_cycle", fall_pulse, 0);

    // 5: malformed flags are ignored and flagged
    do_reset();
    gs(2);
    drive(1, 1, 1, 0);
    chk("t5_ferr_a", flag_error, 1);
    drive(1, 0, 0, 0);
    chk("t5_ferr_b", flag_error, 1);
    gs(1);
    chk("t5_ferr_clear", flag_error, 0);
    chk("t5_run3_no_rise", alarm, 0);
    gs(1);
    chk("t5_rise", alarm, 1);

    // 6: counter saturation, clear with coincident rise, reset mid-arming
    do_reset();
    for (int k = 0; k < 5; k++) begin
      gs(4); ls(4);
    end
    chk("t6_sat_c2", event_count2, 3);
    chk("t6_count_c8", event_count, 5);
    gs(3);
    drive(1, 1, 0, 0, 1'b1);
    chk("t6_clear_rise_c2", event_count2, 1);
    chk("t6_clear_rise_c8", event_count, 1);
    ls(4); gs(2);
    do_reset();
    chk("t6_rst_alarm", alarm, 0);
    chk("t6_rst_count", event_count2, 0);
    gs(3);
    chk("t6_needs_full_run", alarm, 0);
    gs(1);
    chk("t6_rise_after_rst", alarm, 1);

    // Randomized: phases biased toward greater then lesser to force edges
    for (int i = 0; i < 800; i++) begin
      int r, want_g;
      want_g = ((i / 24) % 2) == 0;
      rst = ($urandom_range(0, 149) == 0);
      r = $urandom_range(0, 99);
      in_valid = ($urandom_range(0, 9) != 0);
      clear_count = ($urandom_range(0, 39) == 0);
      if (r < 65) begin
        greater = want_g; lesser = !want_g; equal = 0;
      end else if (r < 80) begin
        greater = !want_g; lesser = want_g; equal = 0;
      end else if (r < 93) begin
        greater = 0; lesser = 0; equal = 1;
      end else begin
        {greater, lesser, equal} = 3'($urandom_range(0, 7));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
